fetch_unit_pq: RTL and testbench

- Parametrised successor of the single-cycle fetch stage: PC register, next-PC select (sequential/jump/branch), synchronous instruction memory and a prefetch queue toward decode.
- Decode consumes instructions over a valid/ready handshake.
- Redirects flush the queue and discard any in-flight read.
- A write port loads programs into instruction memory.

---
 rtl/fetch_unit_pq.sv | 158 +++++++++++++++
 tb/tb_fetch_unit_pq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_pq.sv
// fetch_unit_pq: PC register, next-PC select, synchronous imem and a
// prefetch queue feeding decode over a valid/ready handshake.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   redirect_valid      redirect this cycle (flushes queue and in-flight read)
//   redirect_sel        0 = jump_addr, 1 = branch_addr
//   jump_addr           jump target
//   branch_addr         branch target
//   dec_ready           decode accepts the head entry
//   inst_valid          queue head valid
//   inst, inst_pc       head instruction and its PC
//   pc_misalign         one-cycle pulse, redirect target had low bits set
//   imem_we             imem write enable
//   imem_waddr          imem byte write address
//   imem_wdata          imem write data
//   perf_fetched        pop count (only with FETCH_PERF_CNT_EN)
//   perf_stall          stalled-head cycle count (only with FETCH_PERF_CNT_EN)
//
// Optional macro FETCH_PERF_CNT_EN adds the two performance counters.

module fetch_unit_pq #(
    parameter int ADDR_W    = 32,
    parameter int INST_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int FQ_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic              redirect_sel,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic              dec_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              pc_misalign,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [INST_W-1:0] imem_wdata
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    logic [INST_W-1:0] mem [MEM_DEPTH];
    logic [INST_W-1:0] q_inst [FQ_DEPTH];
    logic [ADDR_W-1:0] q_pc [FQ_DEPTH];

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] if_pc;
    logic              if_busy;
    logic [INST_W-1:0] rdata;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  total;
    logic [ADDR_W-1:0] sel_raw;
    logic [ADDR_W-1:0] target;
    logic              issue;
    logic              push;
    logic              pop;
    logic              unused_bits;

    assign unused_bits = ^imem_waddr;

    assign sel_raw = redirect_sel ? branch_addr : jump_addr;
    assign target  = {sel_raw[ADDR_W-1:2], 2'b00};

    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? q_inst[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? q_pc[rd_ptr] : '0;

    assign pop   = inst_valid && dec_ready;
    assign total = count + CNT_W'(if_busy);
    // A pop frees a slot this edge, so a full pipeline may still issue.
    assign issue = !redirect_valid &&
                   ((total < DEPTH_C) || ((total == DEPTH_C) && pop));
    // A redirect drops the returning read instead of queueing it.
    assign push  = if_busy && !redirect_valid;

    // Read before write on the same word: the read sees the old data.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[imem_waddr[IDX_W+1:2]] <= imem_wdata;
        end
        if (issue) begin
            rdata <= mem[pc[IDX_W+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= rdata;
            q_pc[wr_ptr]   <= if_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            if_pc       <= '0;
            if_busy     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            pc_misalign <= 1'b0;
        end else begin
            pc_misalign <= redirect_valid && (sel_raw[1:0] != 2'b00);
            if (redirect_valid) begin
                pc      <= target;
                if_busy <= 1'b0;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
            end else begin
                if (issue) begin
                    pc    <= pc + ADDR_W'(4);
                    if_pc <= pc;
                end
                if_busy <= issue;
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (inst_valid && !dec_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit_pq.sv
// tb_fetch_unit_pq: directed vector table, hand sequences and a random
// run against a stream-level reference model of fetch_unit_pq.

module tb_fetch_unit_pq;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic        redirect_sel;
    logic [11:0] jump_addr;
    logic [11:0] branch_addr;
    logic        dec_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [11:0] inst_pc;
    logic        pc_misalign;
    logic        imem_we;
    logic [11:0] imem_waddr;
    logic [31:0] imem_wdata;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_model [1024];
    logic [11:0] exp_pc;
    int          since;
    logic        m_mis;

    always #5 clk = ~clk;

    fetch_unit_pq #(
        .ADDR_W(12),
        .INST_W(32),
        .MEM_DEPTH(1024),
        .FQ_DEPTH(4),
        .RESET_PC(12'h000)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_sel(redirect_sel),
        .jump_addr(jump_addr),
        .branch_addr(branch_addr),
        .dec_ready(dec_ready),
        .inst_valid(inst_valid),
        .inst(inst),
        .inst_pc(inst_pc),
        .pc_misalign(pc_misalign),
        .imem_we(imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic        rstv;
        logic        rv;
        logic        rs;
        logic [11:0] ja;
        logic [11:0] ba;
        logic        dr;
        logic        ev;
        logic [31:0] ei;
        logic [11:0] ep;
        logic        em;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] wv(input int i);
        case (i)
            0: return 32'h01234567;
            1: return 32'h89ABCDEF;
            2: return 32'h11111111;
            3: return 32'h22222222;
            default: return 32'h5A000000 ^ (i * 32'h00010003);
        endcase
    endfunction

    function automatic vec_t mk(
        input logic rstv, input logic rv, input logic rs,
        input logic [11:0] ja, input logic [11:0] ba,
        input logic dr, input logic ev, input logic [31:0] ei,
        input logic [11:0] ep, input logic em);
        vec_t v;
        v.rstv = rstv; v.rv = rv; v.rs = rs;
        v.ja = ja; v.ba = ba; v.dr = dr;
        v.ev = ev; v.ei = ei; v.ep = ep; v.em = em;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic rv, input logic rs,
                       input logic [11:0] ja,
                       input logic [11:0] ba,
                       input logic dr);
        logic [11:0] tgt;
        redirect_valid = rv;
        redirect_sel   = rs;
        jump_addr      = ja;
        branch_addr    = ba;
        dec_ready      = dr;
        #1;
        chk("rnd_valid", 32'(inst_valid), 32'(since >= 2));
        if (since >= 2) begin
            chk("rnd_pc", 32'(inst_pc), 32'(exp_pc));
            chk("rnd_inst", inst, mem_model[exp_pc[11:2]]);
        end
        chk("rnd_misalign", 32'(pc_misalign), 32'(m_mis));
        @(posedge clk);
        if (since >= 2 && dr) exp_pc = exp_pc + 12'd4;
        if (rv) begin
            tgt    = rs ? ba : ja;
            exp_pc = {tgt[11:2], 2'b00};
            m_mis  = (tgt[1:0] != 2'b00);
            since  = 0;
        end else begin
            m_mis = 1'b0;
            if (since < 2) since++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_sel   = 1'b0;
        jump_addr      = '0;
        branch_addr    = '0;
        dec_ready      = 1'b0;
        imem_we        = 1'b0;
        imem_waddr     = '0;
        imem_wdata     = '0;

        for (int i = 0; i < 1024; i++) begin
            mem_model[i] = wv(i);
            @(negedge clk);
            imem_we    = 1'b1;
            imem_waddr = 12'(i * 4);
            imem_wdata = wv(i);
        end
        @(negedge clk);
        imem_we = 1'b0;

        // cold start, sequential fetch
        tbl.push_back(mk(0,0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(0),12'h000,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(1),12'h004,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(2),12'h008,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(3),12'h00C,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(4),12'h010,0));
        // mid-run reset, then stall until full
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(1,0,0,0,0,0, 1,wv(0),12'h000,0));
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(1,0,0,0,0,1, 1,wv(i),12'(i*4),0));
        // jump with 2 queued and 1 in flight
        tbl.push_back(mk(0,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0, 1,wv(0),12'h000,0));
        tbl.push_back(mk(1,1,0,12'h040,12'h3F0,0,
                         1,wv(0),12'h000,0));
        tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(16),12'h040,0));
        // misaligned branch together with a pop
        tbl.push_back(mk(1,1,1,12'h999,12'h023,1,
                         1,wv(17),12'h044,0));
        tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(8),12'h020,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(9),12'h024,0));
        // address wrap
        tbl.push_back(mk(1,1,0,12'hFFC,12'h000,1,
                         1,wv(10),12'h028,0));
        tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1, 0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(1023),12'hFFC,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(0),12'h000,0));
        tbl.push_back(mk(1,0,0,0,0,1, 1,wv(1),12'h004,0));

        foreach (tbl[k]) begin
            rst            = tbl[k].rstv;
            redirect_valid = tbl[k].rv;
            redirect_sel   = tbl[k].rs;
            jump_addr      = tbl[k].ja;
            branch_addr    = tbl[k].ba;
            dec_ready      = tbl[k].dr;
            #1;
            chk($sformatf("vec%0d_valid", k),
                32'(inst_valid), 32'(tbl[k].ev));
            if (tbl[k].ev || !tbl[k].rstv) begin
                chk($sformatf("vec%0d_inst", k), inst, tbl[k].ei);
                chk($sformatf("vec%0d_pc", k),
                    32'(inst_pc), 32'(tbl[k].ep));
            end
            chk($sformatf("vec%0d_misalign", k),
                32'(pc_misalign), 32'(tbl[k].em));
            @(posedge clk);
            @(negedge clk);
        end

        // write and read of word 5 on the same edge
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_sel   = 1'b0;
        jump_addr      = 12'h014;
        dec_ready      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_we        = 1'b1;
        imem_waddr     = 12'h014;
        imem_wdata     = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        imem_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("wr_old_valid", 32'(inst_valid), 32'd1);
        chk("wr_old_inst", inst, wv(5));
        chk("wr_old_pc", 32'(inst_pc), 32'h014);
        redirect_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("wr_new_inst", inst, 32'hCAFEF00D);
        chk("wr_new_pc", 32'(inst_pc), 32'h014);
        mem_model[5] = 32'hCAFEF00D;

        // random run against the stream model
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        exp_pc = 12'h000;
        since  = 0;
        m_mis  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)),
                12'($urandom),
                12'($urandom),
                ($urandom_range(0, 9) < 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
